// File: rtl/pwm_ctrl_pkg.sv
// Shared types and default sizing for the lamp PWM fade controller.
package pwm_ctrl_pkg;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_DUTY_W = 8;
  localparam int STEP_W     = 4;

  typedef logic [DEF_DUTY_W-1:0] duty_t;
  typedef logic [1:0]            ch_idx_t;
  typedef logic [STEP_W-1:0]     step_t;

  localparam duty_t DUTY_MAX = '1;

  // A zero step would stall a ramp forever, so it is promoted to one.
  function automatic step_t fix_step(input step_t s);
    return (s == '0) ? step_t'(1) : s;
  endfunction

endpackage

// File: rtl/fade_channel.sv
// One PWM channel: holds current/target duty and steps toward the target
// on each shared tick without overshoot.
module fade_channel
  import pwm_ctrl_pkg::*;
#(
  parameter int DUTY_W = DEF_DUTY_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DUTY_W-1:0] load_target,
  input  logic [STEP_W-1:0] load_step,
  input  logic              tick,
  input  logic              kill,
  output logic [DUTY_W-1:0] duty,
  output logic              busy,
  output logic              done,
  output logic              active_nxt
);

  logic [DUTY_W-1:0] cur_q, cur_d;
  logic [DUTY_W-1:0] target_q, target_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [DUTY_W:0] step_ext;
  logic [DUTY_W:0] up_sum;
  logic [DUTY_W:0] down_gap;

  // Extra bit on the arithmetic so the clamp decision never sees a wrap.
  assign step_ext = {{(DUTY_W+1-STEP_W){1'b0}}, step_q};
  assign up_sum   = {1'b0, cur_q} + step_ext;
  assign down_gap = {1'b0, cur_q} - {1'b0, target_q};

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    cur_d    = cur_q;
    target_d = target_q;
    step_d   = step_q;
    busy_d   = busy_q;
    done_d   = 1'b0;

    if (kill) begin
      cur_d  = '0;
      busy_d = 1'b0;
    end else if (load) begin
      target_d = load_target;
      step_d   = fix_step(load_step);
      if (load_target == cur_q) done_d = 1'b1;
      else                      busy_d = 1'b1;
    end else if (busy_q && tick) begin
      if (cur_q < target_q) begin
        cur_d = (up_sum >= {1'b0, target_q}) ? target_q : up_sum[DUTY_W-1:0];
      end else begin
        cur_d = (down_gap <= step_ext) ? target_q : cur_q - step_ext[DUTY_W-1:0];
      end
      if (cur_d == target_q) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_n) begin
      cur_q    <= '0;
      target_q <= '0;
      step_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      cur_q    <= cur_d;
      target_q <= target_d;
      step_q   <= step_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign duty       = cur_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign active_nxt = busy_d | (cur_d != '0);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Brightness scheduler: accepts per-channel fade commands and ramps each
// channel's PWM duty toward its target on a shared divided tick.
module pwm_fade_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int DUTY_W   = DEF_DUTY_W,
  parameter int TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_ch,
  input  logic [DUTY_W-1:0]        cmd_target,
  input  logic [STEP_W-1:0]        cmd_step,
  input  logic                     kill,
  output logic [NUM_CH*DUTY_W-1:0] duty_o,
  output logic [NUM_CH-1:0]        pwm_en_n,
  output logic [NUM_CH-1:0]        busy,
  output logic [NUM_CH-1:0]        done,
  output logic                     cmd_err
);

  localparam int CNT_W = $clog2(TICK_DIV);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              tick;
  logic              cmd_err_q, cmd_err_d;
  logic [NUM_CH-1:0] pwm_en_n_q, pwm_en_n_d;

  logic [NUM_CH-1:0] ch_hit;
  logic [NUM_CH-1:0] load;
  logic [NUM_CH-1:0] active_nxt;
  logic              ch_ok;
  logic              busy_sel;
  logic              accept;

  assign tick  = (cnt_q == CNT_W'(TICK_DIV - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_comb begin
    ch_hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cmd_ch == ch_idx_t'(i)) ch_hit[i] = 1'b1;
    end
  end

  // Ready is combinational from cmd_ch so a busy channel never blocks others.
  assign ch_ok     = (int'(cmd_ch) < NUM_CH);
  assign busy_sel  = |(ch_hit & busy);
  assign cmd_ready = rst_n & ~kill & ~(ch_ok & busy_sel);
  assign accept    = cmd_valid & cmd_ready;
  assign load      = ch_hit & {NUM_CH{accept}};
  assign cmd_err_d = accept & ~ch_ok;

  // Enable is registered alongside duty so both reach the PWM core together.
  assign pwm_en_n_d = ~active_nxt;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    fade_channel #(
      .DUTY_W (DUTY_W)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .load        (load[g]),
      .load_target (cmd_target),
      .load_step   (cmd_step),
      .tick        (tick),
      .kill        (kill),
      .duty        (duty_o[g*DUTY_W +: DUTY_W]),
      .busy        (busy[g]),
      .done        (done[g]),
      .active_nxt  (active_nxt[g])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      cmd_err_q  <= 1'b0;
      pwm_en_n_q <= '1;
    end else begin
      cnt_q      <= cnt_d;
      cmd_err_q  <= cmd_err_d;
      pwm_en_n_q <= pwm_en_n_d;
    end
  end

  assign cmd_err  = cmd_err_q;
  assign pwm_en_n = pwm_en_n_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Scoreboard bench for pwm_fade_ctrl with a fast tick; expected duty steps
// and done pulses are queued when commands are driven.
module tb_pwm_fade_ctrl;
  import pwm_ctrl_pkg::*;

  localparam int NUM_CH   = 3;
  localparam int DUTY_W   = 8;
  localparam int TICK_DIV = 4;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     cmd_valid = 1'b0;
  logic                     cmd_ready;
  logic [1:0]               cmd_ch = '0;
  logic [DUTY_W-1:0]        cmd_target = '0;
  logic [STEP_W-1:0]        cmd_step = '0;
  logic                     kill = 1'b0;
  logic [NUM_CH*DUTY_W-1:0] duty_o;
  logic [NUM_CH-1:0]        pwm_en_n;
  logic [NUM_CH-1:0]        busy;
  logic [NUM_CH-1:0]        done;
  logic                     cmd_err;

  pwm_fade_ctrl #(
    .NUM_CH   (NUM_CH),
    .DUTY_W   (DUTY_W),
    .TICK_DIV (TICK_DIV)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_ch     (cmd_ch),
    .cmd_target (cmd_target),
    .cmd_step   (cmd_step),
    .kill       (kill),
    .duty_o     (duty_o),
    .pwm_en_n   (pwm_en_n),
    .busy       (busy),
    .done       (done),
    .cmd_err    (cmd_err)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;
  bit mon_en = 1'b0;
  bit flush_mode = 1'b0;

  int exp_duty_q [NUM_CH][$];
  int exp_done   [NUM_CH];
  int model_cur  [NUM_CH];
  int sh_end     [NUM_CH];
  int prev       [NUM_CH];
  int last_cyc   [NUM_CH];

  function automatic bit drained();
    for (int c = 0; c < NUM_CH; c++) begin
      if (exp_duty_q[c].size() != 0 || exp_done[c] != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  // Observes duty changes and done pulses on the falling edge.
  task automatic monitor();
    forever begin
      @(negedge clk);
      cyc++;
      if (mon_en) begin
        for (int c = 0; c < NUM_CH; c++) begin
          int d;
          int e;
          d = int'(duty_o[c*DUTY_W +: DUTY_W]);
          if (d != prev[c]) begin
            n_vec++;
            if (exp_duty_q[c].size() == 0) begin
              n_miss++;
              $display("FAIL duty_change ch%0d: got %0d, expected no change", c, d);
            end else begin
              e = exp_duty_q[c].pop_front();
              if (d !== e) begin
                n_miss++;
                $display("FAIL duty_step ch%0d: got %0d, expected %0d", c, d, e);
              end
              model_cur[c] = e;
              if (!flush_mode && last_cyc[c] >= 0) begin
                n_vec++;
                if (cyc - last_cyc[c] != TICK_DIV) begin
                  n_miss++;
                  $display("FAIL step_spacing ch%0d: got %0d cycles, expected %0d",
                           c, cyc - last_cyc[c], TICK_DIV);
                end
              end
            end
            last_cyc[c] = flush_mode ? -1 : cyc;
            prev[c] = d;
          end
          if (done[c]) begin
            n_vec++;
            if (exp_done[c] == 0) begin
              n_miss++;
              $display("FAIL done_pulse ch%0d: got 1, expected 0", c);
            end else begin
              exp_done[c]--;
              if (busy[c] !== 1'b0) begin
                n_miss++;
                $display("FAIL busy_at_done ch%0d: got %b, expected 0", c, busy[c]);
              end
            end
            last_cyc[c] = -1;
          end
        end
      end
    end
  endtask

  task automatic push_ramp(input int ch, input int tgt, input int stp);
    int v;
    int s;
    v = sh_end[ch];
    s = (stp == 0) ? 1 : stp;
    while (v != tgt) begin
      if (v < tgt) v = (v + s > tgt) ? tgt : v + s;
      else         v = (v - tgt <= s) ? tgt : v - s;
      exp_duty_q[ch].push_back(v);
    end
    exp_done[ch]++;
    sh_end[ch] = tgt;
  endtask

  // Presents one command for one cycle; returns just after the accept edge.
  task automatic drive_cmd(input int ch, input int tgt, input int stp, input bit exp_ready);
    @(negedge clk); #1;
    cmd_valid  = 1'b1;
    cmd_ch     = 2'(ch);
    cmd_target = DUTY_W'(tgt);
    cmd_step   = STEP_W'(stp);
    #1;
    n_vec++;
    if (cmd_ready !== exp_ready) begin
      n_miss++;
      $display("FAIL cmd_ready ch%0d: got %b, expected %b", ch, cmd_ready, exp_ready);
    end
    if (exp_ready && ch < NUM_CH) push_ramp(ch, tgt, stp);
    @(negedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int k;
    k = 0;
    while (!drained() && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    n_vec++;
    if (!drained()) begin
      n_miss++;
      $display("FAIL drain_timeout: got pending expectations after %0d cycles, expected none", k);
      for (int c = 0; c < NUM_CH; c++) begin
        exp_duty_q[c].delete();
        exp_done[c] = 0;
      end
    end
  endtask

  task automatic flush_to_zero();
    flush_mode = 1'b1;
    for (int c = 0; c < NUM_CH; c++) begin
      exp_duty_q[c].delete();
      exp_done[c] = 0;
      if (model_cur[c] != 0) exp_duty_q[c].push_back(0);
      sh_end[c] = 0;
    end
  endtask

  task automatic check_idle_all(input string tag, input logic exp_ready);
    n_vec++;
    if (duty_o !== '0 || pwm_en_n !== 3'b111 || busy !== 3'b000 || cmd_ready !== exp_ready) begin
      n_miss++;
      $display("FAIL %s: got duty=%h en_n=%b busy=%b ready=%b, expected duty=0 en_n=111 busy=000 ready=%b",
               tag, duty_o, pwm_en_n, busy, cmd_ready, exp_ready);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_idle_all("reset_hold", 1'b0);
    n_vec++;
    if (done !== 3'b000 || cmd_err !== 1'b0) begin
      n_miss++;
      $display("FAIL reset_pulses: got done=%b err=%b, expected 000 0", done, cmd_err);
    end
    rst_n = 1'b1;
    mon_en = 1'b1;
    repeat (20) @(negedge clk);
    #1;
    check_idle_all("reset_release", 1'b1);
  endtask

  task automatic test_ramp_up();
    drive_cmd(0, 10, 3, 1'b1);
    n_vec++;
    if (pwm_en_n[0] !== 1'b0 || busy[0] !== 1'b1) begin
      n_miss++;
      $display("FAIL ramp_up_start: got en_n0=%b busy0=%b, expected 0 1", pwm_en_n[0], busy[0]);
    end
    wait_drain(100);
    repeat (8) @(negedge clk);
    #1;
    n_vec++;
    if (busy[0] !== 1'b0 || pwm_en_n[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL ramp_up_end: got busy0=%b en_n0=%b, expected 0 0", busy[0], pwm_en_n[0]);
    end
  endtask

  task automatic test_ramp_down_step0();
    drive_cmd(1, 10, 10, 1'b1);
    wait_drain(100);
    drive_cmd(1, 0, 0, 1'b1);
    n_vec++;
    if (busy[1] !== 1'b1) begin
      n_miss++;
      $display("FAIL ramp_down_start: got busy1=%b, expected 1", busy[1]);
    end
    wait_drain(200);
    n_vec++;
    if (busy[1] !== 1'b0 || pwm_en_n[1] !== 1'b1) begin
      n_miss++;
      $display("FAIL ramp_down_end: got busy1=%b en_n1=%b, expected 0 1", busy[1], pwm_en_n[1]);
    end
  endtask

  task automatic test_back_to_back();
    drive_cmd(0, 100, 5, 1'b1);
    for (int i = 0; i < 3; i++) drive_cmd(0, 50, 1, 1'b0);
    drive_cmd(2, 200, 15, 1'b1);
    n_vec++;
    if (busy[0] !== 1'b1 || busy[2] !== 1'b1) begin
      n_miss++;
      $display("FAIL concurrent_busy: got busy=%b, expected 1x1", busy);
    end
    wait_drain(400);
  endtask

  task automatic test_kill();
    drive_cmd(0, 0, 1, 1'b1);
    drive_cmd(2, 50, 5, 1'b1);
    repeat (10) @(negedge clk);
    #1;
    flush_to_zero();
    kill       = 1'b1;
    cmd_valid  = 1'b1;
    cmd_ch     = 2'd1;
    cmd_target = 8'd77;
    cmd_step   = 4'd1;
    #1;
    n_vec++;
    if (cmd_ready !== 1'b0) begin
      n_miss++;
      $display("FAIL kill_ready: got %b, expected 0", cmd_ready);
    end
    repeat (3) begin
      @(negedge clk); #1;
      check_idle_all("kill_hold", 1'b0);
    end
    kill      = 1'b0;
    cmd_valid = 1'b0;
    wait_drain(20);
    repeat (4) @(negedge clk);
    #1;
    flush_mode = 1'b0;
  endtask

  task automatic test_cmd_err_and_equal();
    drive_cmd(3, 5, 1, 1'b1);
    n_vec++;
    if (cmd_err !== 1'b1) begin
      n_miss++;
      $display("FAIL cmd_err_pulse: got %b, expected 1", cmd_err);
    end
    @(negedge clk); #1;
    n_vec++;
    if (cmd_err !== 1'b0) begin
      n_miss++;
      $display("FAIL cmd_err_width: got %b, expected 0", cmd_err);
    end
    check_idle_all("cmd_err_state", 1'b1);

    drive_cmd(0, 40, 15, 1'b1);
    wait_drain(100);
    drive_cmd(0, 40, 7, 1'b1);
    n_vec++;
    if (done[0] !== 1'b1 || busy[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL equal_target: got done0=%b busy0=%b, expected 1 0", done[0], busy[0]);
    end
    @(negedge clk); #1;
    n_vec++;
    if (done[0] !== 1'b0 || busy[0] !== 1'b0 || pwm_en_n[0] !== 1'b0) begin
      n_miss++;
      $display("FAIL equal_after: got done0=%b busy0=%b en_n0=%b, expected 0 0 0",
               done[0], busy[0], pwm_en_n[0]);
    end
  endtask

  task automatic test_reset_midramp();
    drive_cmd(2, 100, 1, 1'b1);
    repeat (20) @(negedge clk);
    #1;
    flush_to_zero();
    rst_n = 1'b0;
    @(negedge clk); #1;
    check_idle_all("reset_midramp", 1'b0);
    rst_n = 1'b1;
    wait_drain(20);
    repeat (12) @(negedge clk);
    #1;
    flush_mode = 1'b0;
    check_idle_all("reset_midramp_after", 1'b1);
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      exp_done[c]  = 0;
      model_cur[c] = 0;
      sh_end[c]    = 0;
      prev[c]      = 0;
      last_cyc[c]  = -1;
    end
    fork
      monitor();
    join_none
    test_reset();
    test_ramp_up();
    test_ramp_down_step0();
    test_back_to_back();
    test_kill();
    test_cmd_err_and_equal();
    test_reset_midramp();
    wait_drain(50);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
